// File: rtl/line_pid_pkg.sv
// ----------------------------------------------------------------------------
// line_pid_pkg
// Shared constants and helpers for the line-following PID steering stage.
//   - Gain coefficients for the P and D paths.
//   - Forward ramp limit and per-sample increments (slow / fast-sim).
//   - Datapath widths used across the top and the D-term sub-module.
//   - sat_signed(): clamp a 32-bit signed value into an N-bit signed range.
// Optional feature macro used by the design: LINE_PID_DTERM_EN.
// ----------------------------------------------------------------------------
package line_pid_pkg;

    localparam int IN_W      = 16;  // raw error / open-loop word
    localparam int ERR_W     = 10;  // saturated error
    localparam int DIFF_IN_W = 11;  // error difference before saturation
    localparam int DIFF_W    = 7;   // saturated error difference
    localparam int TERM_W    = 14;  // P, I, D terms and their sum
    localparam int SPD_W     = 12;  // wheel speed commands
    localparam int SUM_W     = 15;  // forward speed +/- pid before clamp
    localparam int INTEG_W   = 15;  // integrator register
    localparam int I_SHIFT   = 6;   // integrator LSBs dropped for the I term
    localparam int FRWRD_W   = 11;  // forward ramp register

    localparam int P_COEFF = 3;
    localparam int D_COEFF = 5;

    localparam logic [FRWRD_W-1:0] FRWRD_MAX      = 11'd672;
    localparam logic [FRWRD_W-1:0] FRWRD_INC_SLOW = 11'd2;
    localparam logic [FRWRD_W-1:0] FRWRD_INC_FAST = 11'd16;

    // Clamp val into [-(2^(width-1)), 2^(width-1)-1]; callers cast the
    // result down to the width they asked for.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/line_pid_dterm.sv
// ----------------------------------------------------------------------------
// line_pid_dterm
// Derivative path of the line PID: keeps the saturated error of the two
// previous samples and produces D = sat7(err - err[-2]) * D_COEFF.
// Built only when LINE_PID_DTERM_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear of the history (go low)
//   shift_i     a new sample is being accepted this cycle
//   err_sat_i   saturated error of the most recent accepted sample
//   d_term_o    D term (combinational, from err_sat_i and the history)
// ----------------------------------------------------------------------------
`ifdef LINE_PID_DTERM_EN
module line_pid_dterm
    import line_pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     shift_i,
    input  logic signed [ERR_W-1:0]  err_sat_i,
    output logic signed [TERM_W-1:0] d_term_o
);

    logic signed [ERR_W-1:0]     hist1_q, hist1_d;
    logic signed [ERR_W-1:0]     hist2_q, hist2_d;
    logic signed [DIFF_IN_W-1:0] diff;
    logic signed [DIFF_W-1:0]    diff_sat;

    // err_sat_i still holds the previous sample on the edge that accepts a
    // new one, so shifting it in keeps hist2 exactly two samples behind.
    always_comb begin
        hist1_d = hist1_q;
        hist2_d = hist2_q;
        if (clr_i) begin
            hist1_d = '0;
            hist2_d = '0;
        end else if (shift_i) begin
            hist1_d = err_sat_i;
            hist2_d = hist1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= '0;
            hist2_q <= '0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end

    assign diff     = DIFF_IN_W'(err_sat_i) - DIFF_IN_W'(hist2_q);
    assign diff_sat = DIFF_W'(sat_signed(32'(diff), DIFF_W));
    assign d_term_o = TERM_W'(diff_sat) * TERM_W'(D_COEFF);

endmodule
`endif

// File: rtl/line_pid.sv
// ----------------------------------------------------------------------------
// line_pid
// PID steering stage: turns the signed line error into saturated left/right
// wheel speed commands around a forward speed that ramps up after go rises.
// Three-stage pipeline: input/integrator/ramp, P-I-D terms, wheel outputs.
// Parameters:
//   FAST_SIM    1 = fast ramp (16/sample) and integrate every sample
// Configuration macro:
//   LINE_PID_DTERM_EN  builds the derivative path; otherwise D is 0
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   go           run enable; low clears every stage on the next edge
//   err_vld      one-cycle strobe, err_opn_lp carries a new sample
//   err_opn_lp   signed 16-bit error / open-loop value
//   lft_spd      signed 12-bit left wheel command
//   rght_spd     signed 12-bit right wheel command
//   spd_vld      one-cycle strobe, speed outputs just updated
// ----------------------------------------------------------------------------
module line_pid
    import line_pid_pkg::*;
#(
    parameter int FAST_SIM = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic                    err_vld,
    input  logic signed [IN_W-1:0]  err_opn_lp,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    spd_vld
);

    localparam logic [FRWRD_W-1:0] FRWRD_INC  = (FAST_SIM != 0) ? FRWRD_INC_FAST : FRWRD_INC_SLOW;
    localparam logic [1:0]         DECIM_LAST = 2'd3;

    // Stage 1
    logic signed [ERR_W-1:0]   err_sat_q, err_sat_d;
    logic [FRWRD_W-1:0]        frwrd_q, frwrd_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic [1:0]                decim_q, decim_d;
    logic                      v1_q, v1_d;
    // Stage 2
    logic signed [TERM_W-1:0]  p_q, p_d;
    logic signed [TERM_W-1:0]  i_q, i_d;
    logic signed [TERM_W-1:0]  d_q, d_d;
    logic [FRWRD_W-1:0]        frwrd2_q, frwrd2_d;
    logic                      v2_q, v2_d;
    // Stage 3
    logic signed [SPD_W-1:0]   lft_q, lft_d;
    logic signed [SPD_W-1:0]   rght_q, rght_d;
    logic                      vld_q, vld_d;

    logic signed [ERR_W-1:0]   err_sat_in;
    logic signed [TERM_W-1:0]  d_term;
    logic signed [TERM_W-1:0]  pid;
    logic signed [SUM_W-1:0]   frwrd_ext;
    logic signed [SUM_W-1:0]   lft_sum;
    logic signed [SUM_W-1:0]   rght_sum;

    assign err_sat_in = ERR_W'(sat_signed(32'(err_opn_lp), ERR_W));

`ifdef LINE_PID_DTERM_EN
    line_pid_dterm u_dterm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!go),
        .shift_i   (go && err_vld),
        .err_sat_i (err_sat_q),
        .d_term_o  (d_term)
    );
`else
    assign d_term = '0;
`endif

    // Stage 1: accept a sample. The integrator refuses any add that would
    // flip its sign against two like-signed operands, so it sticks at the
    // last in-range value instead of wrapping.
    always_comb begin
        logic [FRWRD_W:0]          frwrd_sum;
        logic signed [INTEG_W-1:0] integ_sum;
        logic                      integ_ovf;
        logic                      integ_take;

        err_sat_d = err_sat_q;
        frwrd_d   = frwrd_q;
        integ_d   = integ_q;
        decim_d   = decim_q;
        v1_d      = 1'b0;

        frwrd_sum  = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
        integ_sum  = integ_q + INTEG_W'(err_sat_in);
        integ_ovf  = (integ_q[INTEG_W-1] == err_sat_in[ERR_W-1]) &&
                     (integ_sum[INTEG_W-1] != integ_q[INTEG_W-1]);
        integ_take = (FAST_SIM != 0) || (decim_q == DECIM_LAST);

        if (!go) begin
            err_sat_d = '0;
            frwrd_d   = '0;
            integ_d   = '0;
            decim_d   = '0;
        end else if (err_vld) begin
            err_sat_d = err_sat_in;
            frwrd_d   = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[FRWRD_W-1:0];
            decim_d   = decim_q + 2'd1;
            if (integ_take && !integ_ovf) begin
                integ_d = integ_sum;
            end
            v1_d = 1'b1;
        end
    end

    // Stage 2: P, I and D terms, plus a copy of the ramp aligned to them.
    always_comb begin
        p_d      = p_q;
        i_d      = i_q;
        d_d      = d_q;
        frwrd2_d = frwrd2_q;
        v2_d     = 1'b0;
        if (!go) begin
            p_d      = '0;
            i_d      = '0;
            d_d      = '0;
            frwrd2_d = '0;
        end else if (v1_q) begin
            p_d      = TERM_W'(err_sat_q) * TERM_W'(P_COEFF);
            i_d      = TERM_W'($signed(integ_q[INTEG_W-1:I_SHIFT]));
            d_d      = d_term;
            frwrd2_d = frwrd_q;
            v2_d     = 1'b1;
        end
    end

    // Stage 3: the pid sum is bounded well inside 14 bits, so only the
    // wheel commands need clamping.
    assign pid       = p_q + i_q + d_q;
    assign frwrd_ext = $signed({{(SUM_W - FRWRD_W){1'b0}}, frwrd2_q});
    assign lft_sum   = frwrd_ext + SUM_W'(pid);
    assign rght_sum  = frwrd_ext - SUM_W'(pid);

    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        vld_d  = 1'b0;
        if (!go) begin
            lft_d  = '0;
            rght_d = '0;
        end else if (v2_q) begin
            lft_d  = SPD_W'(sat_signed(32'(lft_sum), SPD_W));
            rght_d = SPD_W'(sat_signed(32'(rght_sum), SPD_W));
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat_q <= '0;
            frwrd_q   <= '0;
            integ_q   <= '0;
            decim_q   <= '0;
            v1_q      <= 1'b0;
            p_q       <= '0;
            i_q       <= '0;
            d_q       <= '0;
            frwrd2_q  <= '0;
            v2_q      <= 1'b0;
            lft_q     <= '0;
            rght_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            err_sat_q <= err_sat_d;
            frwrd_q   <= frwrd_d;
            integ_q   <= integ_d;
            decim_q   <= decim_d;
            v1_q      <= v1_d;
            p_q       <= p_d;
            i_q       <= i_d;
            d_q       <= d_d;
            frwrd2_q  <= frwrd2_d;
            v2_q      <= v2_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            vld_q     <= vld_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign spd_vld  = vld_q;

endmodule

// File: doc/line_pid.md
# line_pid

PID steering-control stage directly downstream of the command processor. It consumes the signed line-error/open-loop word `err_opn_lp` and the `go` enable. It produces registered, saturated left/right wheel speed commands for the motor-drive stage. It also contains a forward-speed ramp, so the robot accelerates smoothly every time `go` asserts.

## Interface
- `FAST_SIM`, default 0: 1 shortens the forward ramp and integrator decimation, for simulation.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `go`  in  1  enable from the command processor; low means stop and clear.
- `err_vld`  in  1  one-cycle strobe; a new `err_opn_lp` sample is present.
- `err_opn_lp`  in  16  signed error / open-loop value.
- `lft_spd`  out  12  signed left speed command.
- `rght_spd`  out  12  signed right speed command.
- `spd_vld`  out  1  one-cycle strobe; the speed outputs were updated.

## Operation
- Input saturation: `err_sat` = `err_opn_lp` saturated to 10-bit signed [-512, 511].
- Sample update: on each `err_vld` with `go` = 1, update the forward ramp, the integrator and the D history.
- Forward ramp:
  - `frwrd` is an 11-bit unsigned register.
  - Each sample adds FRWRD_INC: 2 when FAST_SIM=0, 16 when FAST_SIM=1.
  - It clamps at FRWRD_MAX = 672.
- P term: `err_sat` × P_COEFF (3), as 14-bit signed.
- Integrator register:
  - `integ` is 15-bit signed.
  - It adds sign-extended `err_sat` on every sample when FAST_SIM=1, and on every 4th sample when FAST_SIM=0.
  - Overflow rule: if both operands have the same sign and the sum's sign differs, `integ` holds its value (it does not wrap).
- I term: `integ[14:6]` (9-bit signed, [-256, 255]), sign-extended to 14 bits.
- D history and D term:
  - A 2-deep history holds `err_sat` from the previous two samples.
  - `d_diff` = `err_sat` − the sample from 2 samples ago, saturated to 7-bit signed [-64, 63].
  - D term = `d_diff` × D_COEFF (5), sign-extended to 14 bits.
- Sum: `pid` = P + I + D, 14-bit signed; this cannot overflow.
- Wheel commands:
  - `lft_spd` = sat12(`frwrd` + `pid`).
  - `rght_spd` = sat12(`frwrd` − `pid`).
  - sat12 saturates to [-2048, 2047].
- `go` low:
  - `integ`, the history, `frwrd`, the decimation counter and all pipeline registers clear on the next edge.
  - Outputs become 0 and `spd_vld` = 0.
  - If `go` falls in the same cycle as `err_vld`, the clear wins and the sample is discarded.
- `go` rising: the ramp restarts from 0. The first sample compares against a zero history.

## Timing
- Reset: `lft_spd` = 0, `rght_spd` = 0, `spd_vld` = 0, and all internal registers are 0.
- Pipeline, for an `err_vld` sampled at edge N:
  - Stage 1 (`err_sat`, `integ`, history, `frwrd`) updates at edge N.
  - Stage 2 (P, I, D terms and `frwrd` copy) updates at edge N+1.
  - Stage 3 (`lft_spd`, `rght_spd`, `spd_vld` = 1) updates at edge N+2.
- Latency: `spd_vld` is high for exactly one cycle, two clocks after the strobe edge.
- Between strobes, the outputs hold their values.
- Back-to-back `err_vld` on consecutive cycles is legal and fully pipelined, one result per strobe.
- Reset asserted mid-pipeline: all stages clear immediately and no `spd_vld` is issued.

## Configuration
- Macro: `LINE_PID_DTERM_EN`.
- Defined: the D history and D term are present as described above.
- Undefined:
  - The D term is the constant 0 and the history registers are not built.
  - P and I behaviour, the ramp and the latency are unchanged.

## Structure
- Package `line_pid_pkg` holds:
  - P_COEFF and D_COEFF;
  - FRWRD_MAX, FRWRD_INC_SLOW and FRWRD_INC_FAST;
  - width localparams (ERR_W = 10, TERM_W = 14, SPD_W = 12);
  - a signed saturation function.
- One sub-module, `line_pid_dterm`:
  - contains the 2-deep history, `d_diff` saturation and the D multiply;
  - is instantiated only under `LINE_PID_DTERM_EN`.

## Test plan
Unless stated otherwise, all scenarios use FAST_SIM=1 and `LINE_PID_DTERM_EN` defined.
- Ramp: assert reset, then `go` = 1 with `err_opn_lp` = 0 strobed 50 times.
  - Before the first strobe, all outputs are 0.
  - `lft_spd` = `rght_spd` = 16, 32, …, reaching 672 at strobe 42 and holding 672.
- Positive saturation: after the ramp, strobe `err_opn_lp` = 16'h7FFF 100 times.
  - I saturates at 255 and D settles at 0.
  - `lft_spd` = 2047 (saturated from 2460) and `rght_spd` = −1116.
- Negative saturation: same as above with 16'h8000.
  - `lft_spd` = −1120 and `rght_spd` = 2047.
- D step: from steady error 0 at `frwrd` = 672, strobe 20 three times.
  - `lft_spd` = 832, 832, 732.
  - `rght_spd` = 512, 512, 612.
  - Each `spd_vld` arrives 2 cycles after its `err_vld`.
- `go` drop mid-operation, with `go` falling coincident with `err_vld`:
  - Next edge: outputs are 0 and no `spd_vld` is issued.
  - After re-asserting `go` with error 0, the first `lft_spd` = 16 (integrator cleared).
- `LINE_PID_DTERM_EN` undefined: repeat the D step.
  - `lft_spd` = 732, 732, 732.
